// File: rtl/cmos_video_tx_if.sv
// Upstream pixel stream into cmos_video_tx: 24-bit RGB888 words over valid/ready.
// A pixel transfers on any clock edge where pix_valid and pix_ready are both high;
// pix_ready is driven by the sink alone and never waits on pix_valid.
interface cmos_video_tx_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/cmos_video_tx.sv
// CMOS-style video source: pulls RGB888 pixels from upstream and emits VSYNC/HREF/CLKEN/DATA
// with fixed frame/line timing. The raster never stretches; a missing pixel is sent as zero.
module cmos_video_tx #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 160,
    parameter int VSYNC_LEN = 2,
    parameter int V_BACK    = 10,
    parameter int V_FRONT   = 10,
    parameter int CNT_W     = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    cmos_video_tx_if.slave     pix,
    output logic               CMOS_VSYNC,
    output logic               CMOS_HREF,
    output logic               CMOS_CLKEN,
    output logic [23:0]        CMOS_DATA,
    output logic [CNT_W-1:0]   X_POS,
    output logic [CNT_W-1:0]   Y_POS,
    output logic               frame_start,
    output logic               underrun,
    output logic [2:0]         state_dbg
);

    localparam int LINE_LEN = IMG_HDISP + H_BLANK;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [CNT_W-1:0]   v_q, v_d;   // line index within the current region
    logic [CNT_W-1:0]   region_lines;
    logic               line_end;
    logic               region_end;
    logic               pix_slot;
    logic               frame_first;

    // State and raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Next state: regions advance only on the last cycle of their last line
    always_comb begin
        region_lines = '0;
        case (state_q)
            S_VSYNC:  region_lines = CNT_W'(VSYNC_LEN);
            S_VBACK:  region_lines = CNT_W'(V_BACK);
            S_ACTIVE: region_lines = CNT_W'(IMG_VDISP);
            S_VFRONT: region_lines = CNT_W'(V_FRONT);
            default:  region_lines = '0;
        endcase
        line_end   = (h_q == CNT_W'(LINE_LEN - 1));
        region_end = line_end && (v_q == region_lines - CNT_W'(1));

        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (state_q == S_IDLE) begin
            h_d = '0;
            v_d = '0;
            if (en) state_d = S_VSYNC;
        end else begin
            h_d = line_end ? '0 : h_q + CNT_W'(1);
            if (region_end) begin
                v_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = (V_FRONT > 0) ? S_VFRONT : (en ? S_VSYNC : S_IDLE);
                    S_VFRONT: state_d = en ? S_VSYNC : S_IDLE;
                    default:  state_d = S_IDLE;
                endcase
            end else if (line_end) begin
                v_d = v_q + CNT_W'(1);
            end
        end
    end

    // Combinational outputs: pixel slot strobe and first-cycle-of-frame marker
    always_comb begin
        pix_slot      = (state_q == S_ACTIVE) && (h_q < CNT_W'(IMG_HDISP));
        frame_first   = (state_q == S_VSYNC) && (h_q == '0) && (v_q == '0);
        pix.pix_ready = pix_slot;
        state_dbg     = state_q;
    end

    // Video outputs lag the state by one cycle, so VSYNC and HREF stay mutually aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            CMOS_VSYNC  <= 1'b0;
            CMOS_HREF   <= 1'b0;
            CMOS_CLKEN  <= 1'b0;
            CMOS_DATA   <= '0;
            X_POS       <= '0;
            Y_POS       <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            CMOS_VSYNC  <= (state_q == S_VSYNC);
            frame_start <= frame_first;
            CMOS_HREF   <= pix_slot;
            CMOS_CLKEN  <= pix_slot;
            CMOS_DATA   <= (pix_slot && pix.pix_valid) ? pix.pix_data : 24'h0;
            X_POS       <= pix_slot ? h_q : '0;
            Y_POS       <= pix_slot ? v_q : '0;
            // Clear wins over set so a new frame always starts clean
            if (frame_first)
                underrun <= 1'b0;
            else if (pix_slot && !pix.pix_valid)
                underrun <= 1'b1;
        end
    end

endmodule

// File: doc/cmos_video_tx.md
Name: cmos_video_tx

Overview:
- Synthesizable transmitter for the team's CMOS-style video interface (VSYNC/HREF/CLKEN/24-bit DATA), as consumed by VIP_RGB888_YCbCr444 and the filter chain.
- Pulls RGB888 pixels from an upstream FIFO/frame reader over valid/ready and emits them with programmable frame/line timing.
- Replaces the behavioural camera model on hardware; it is the source-side counterpart of the video capture sink.

Parameters:
- IMG_HDISP, 640, active pixels per line
- IMG_VDISP, 480, active lines per frame
- H_BLANK, 160, blanking cycles per line after active pixels (>=1)
- VSYNC_LEN, 2, lines with VSYNC high at frame start (>=1)
- V_BACK, 10, blank lines between VSYNC fall and first active line
- V_FRONT, 10, blank lines after last active line
- CNT_W, 12, width of X_POS/Y_POS and internal counters

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable, sampled only at frame boundaries
- pix_valid  in  1  upstream pixel available
- pix_data  in  24  upstream pixel {R[23:16],G[15:8],B[7:0]}
- pix_ready  out  1  pixel consumed this cycle
- CMOS_VSYNC  out  1  frame sync, high during VSYNC lines
- CMOS_HREF  out  1  active-pixel qualifier
- CMOS_CLKEN  out  1  data strobe, equal to CMOS_HREF
- CMOS_DATA  out  24  pixel data, valid when CMOS_CLKEN
- X_POS  out  CNT_W  column of current output pixel (0..IMG_HDISP-1), 0 outside HREF
- Y_POS  out  CNT_W  row of current output pixel, 0 outside active lines
- frame_start  out  1  one-cycle pulse on first VSYNC cycle of each frame
- underrun  out  1  sticky flag: pixel missing during active region in current frame

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, all counters 0, all outputs 0 (pix_ready, VSYNC, HREF, CLKEN, DATA, X/Y_POS, frame_start, underrun). Reset mid-frame aborts immediately. The next frame starts with a full VSYNC.
- Line length L = IMG_HDISP + H_BLANK cycles. h_cnt counts 0..L-1 and wraps; v_cnt increments at each wrap.
- FSM states and transitions:
  - IDLE: on en=1, go to VSYNC next cycle with h_cnt=0.
  - VSYNC: VSYNC_LEN lines, then VBACK (skip if V_BACK=0).
  - VBACK: V_BACK lines, then ACTIVE.
  - ACTIVE: IMG_VDISP lines, then VFRONT (skip if V_FRONT=0).
  - VFRONT: V_FRONT lines. At the end, go to VSYNC if en=1, else IDLE.
  - en is ignored at all other times; a frame always completes once started.
- Output registers:
  - CMOS_VSYNC is registered high for every cycle of the VSYNC state.
  - frame_start is registered high on the first VSYNC cycle only.
- Active pixels:
  - pix_ready is combinational, = (state==ACTIVE && h_cnt<IMG_HDISP). It does not depend on pix_valid.
  - In such a cycle, the next edge registers CMOS_HREF=CMOS_CLKEN=1, X_POS=h_cnt and Y_POS=active line index.
  - CMOS_DATA = pix_valid ? pix_data : 24'h0.
  - Output latency is 1 cycle from the ready cycle. HREF is high for exactly IMG_HDISP consecutive cycles per active line.
- Underrun:
  - If pix_valid=0 while pix_ready=1, the pixel slot is still emitted with data 0; timing is never stretched.
  - underrun is set at the next edge and holds until the next frame_start cycle clears it.
  - If an underrun and frame_start coincide, clear has priority; this cannot occur legally.
- Outside HREF: CMOS_DATA is held at 0, and X_POS/Y_POS are 0.
- Frame period = (VSYNC_LEN+V_BACK+IMG_VDISP+V_FRONT) × L cycles. Back-to-back frames have no gap cycles.

Test Plan:
- Use small parameters for all scenarios: IMG_HDISP=4, IMG_VDISP=3, H_BLANK=2, VSYNC_LEN=1, V_BACK=1, V_FRONT=1, so L=6 and the frame is 36 cycles.
- Reset/idle: rst=1 for 3 cycles, en=0 for 50 cycles -> all outputs remain 0 and pix_ready stays 0.
- Single frame: en=1 for 1 cycle, pix_valid=1, pix_data incrementing from 1 -> frame_start pulse, then VSYNC high 6 cycles, 6 blank cycles, then 3 HREF bursts of 4 cycles separated by 2 low cycles. DATA=1..12 and X_POS 0..3 per line, Y_POS 0..2. Then IDLE after 36 cycles.
- Continuous: en held 1 -> frame_start pulses exactly every 36 cycles, 12 pix_ready cycles per frame.
- Underrun: pix_valid=0 on the 6th active pixel -> that CLKEN slot carries DATA=0, HREF timing unchanged, underrun=1 from the following cycle until the next frame_start.
- Reset mid-frame: rst=1 during active line 1 -> next cycle all outputs 0. After release with en=1, a fresh VSYNC starts and Y_POS restarts at 0.
- en drop: en=0 during the ACTIVE state -> the frame completes fully, then the block goes IDLE with no further frame_start.
